// File: rtl/hazard_scoreboard.sv
// In-order pipeline hazard scoreboard: tracks in-flight writers, selects forwarding sources,
// raises load-use stalls and sequences exception flushes that may be deferred by an external freeze.
module hazard_scoreboard #(
  parameter int NREG      = 32,
  parameter int NSTAGE    = 3,
  parameter int EXC_STAGE = 1,
  parameter int CNTW      = 32
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        d_valid,
  input  logic [$clog2(NREG)-1:0]     d_rs,
  input  logic [$clog2(NREG)-1:0]     d_rt,
  input  logic                        d_rs_used,
  input  logic                        d_rt_used,
  input  logic                        d_wen,
  input  logic [$clog2(NREG)-1:0]     d_waddr,
  input  logic [$clog2(NSTAGE+1)-1:0] d_lat,
  input  logic                        ext_stall,
  input  logic                        exc_req,
  output logic [$clog2(NSTAGE+1)-1:0] rs_fwd,
  output logic [$clog2(NSTAGE+1)-1:0] rt_fwd,
  output logic                        stall_f,
  output logic                        stall_d,
  output logic                        flush_d,
  output logic                        flush_e,
  output logic                        d_issue,
  output logic [CNTW-1:0]             hz_stall_cnt
);

  localparam int AW = $clog2(NREG);
  localparam int LW = $clog2(NSTAGE+1);

  typedef enum logic {IDLE, FLUSH_PEND} state_e;

  state_e              state_q;
  logic [NSTAGE-1:0]   valid_q, valid_d;
  logic [AW-1:0]       waddr_q [NSTAGE];
  logic [AW-1:0]       waddr_d [NSTAGE];
  logic [LW-1:0]       rem_q   [NSTAGE];
  logic [LW-1:0]       rem_d   [NSTAGE];
  logic [CNTW-1:0]     cnt_q;

  logic [LW-1:0]       rs_fwd_c, rt_fwd_c;
  logic                rs_haz, rt_haz, hazard;
  logic                advance, flush, issue, cnt_inc;
  logic [NSTAGE-1:0]   keep;

  // Scan oldest to youngest so the youngest matching writer overrides.
  always_comb begin
    rs_fwd_c = '0;
    rt_fwd_c = '0;
    rs_haz   = 1'b0;
    rt_haz   = 1'b0;
    for (int i = NSTAGE-1; i >= 0; i--) begin
      if (d_rs_used && d_rs != '0 && valid_q[i] && waddr_q[i] == d_rs) begin
        rs_haz   = (rem_q[i] != '0);
        rs_fwd_c = (rem_q[i] == '0) ? LW'(i+1) : '0;
      end
      if (d_rt_used && d_rt != '0 && valid_q[i] && waddr_q[i] == d_rt) begin
        rt_haz   = (rem_q[i] != '0);
        rt_fwd_c = (rem_q[i] == '0) ? LW'(i+1) : '0;
      end
    end
  end

  assign hazard  = rs_haz | rt_haz;
  assign advance = !ext_stall;
  assign flush   = !ext_stall && ((state_q == IDLE && exc_req) || state_q == FLUSH_PEND);
  assign issue   = d_valid && !hazard && !ext_stall && state_q == IDLE && !exc_req;
  assign cnt_inc = advance && hazard && !flush && !(&cnt_q);

  always_comb begin
    for (int i = 0; i < NSTAGE; i++) begin
      keep[i] = valid_q[i] && !(flush && i <= EXC_STAGE);
    end
    valid_d[0] = issue && d_wen && d_waddr != '0;
    waddr_d[0] = d_waddr;
    rem_d[0]   = d_lat;
    for (int i = 1; i < NSTAGE; i++) begin
      valid_d[i] = keep[i-1];
      waddr_d[i] = waddr_q[i-1];
      rem_d[i]   = (rem_q[i-1] == '0) ? '0 : rem_q[i-1] - LW'(1);
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
      for (int i = 0; i < NSTAGE; i++) begin
        waddr_q[i] <= '0;
        rem_q[i]   <= '0;
      end
    end else begin
      case (state_q)
        IDLE:       if (exc_req && ext_stall) state_q <= FLUSH_PEND;
        FLUSH_PEND: if (!ext_stall)           state_q <= IDLE;
        default:                              state_q <= IDLE;
      endcase
      if (advance) begin
        valid_q <= valid_d;
        for (int i = 0; i < NSTAGE; i++) begin
          waddr_q[i] <= waddr_d[i];
          rem_q[i]   <= rem_d[i];
        end
      end
      if (cnt_inc) cnt_q <= cnt_q + CNTW'(1);
    end
  end

  // Control outputs are forced quiet while reset is held, regardless of live inputs.
  assign rs_fwd       = resetn ? rs_fwd_c : '0;
  assign rt_fwd       = resetn ? rt_fwd_c : '0;
  assign stall_f      = resetn && (ext_stall || (hazard && !flush));
  assign stall_d      = resetn && (ext_stall || (hazard && !flush));
  assign flush_d      = resetn && flush;
  assign flush_e      = resetn && (flush || (hazard && !ext_stall));
  assign d_issue      = resetn && issue;
  assign hz_stall_cnt = cnt_q;

endmodule
